// File: rtl/p1v_reset_pkg.sv
// Shared state type, board-level defaults and sizing helpers for the P1V reset controller.
package p1v_reset_pkg;

    typedef enum logic [1:0] {
        POR,
        HOLD,
        STRETCH,
        RUN
    } reset_state_t;

    localparam int         P1V_NUM_SRC         = 2;
    localparam int         P1V_SYNC_STAGES     = 2;
    localparam int         P1V_DEBOUNCE_CYCLES = 8;
    localparam logic [7:0] P1V_DEBOUNCE_MASK   = 8'b0000_0001;
    localparam logic [7:0] P1V_ACTIVE_LOW_MASK = 8'b0000_0010;
    localparam int         P1V_STRETCH_CYCLES  = 16;
    localparam int         P1V_POR_CYCLES      = 32;

    function automatic int cnt_w(input int max_cnt);
        return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/p1v_reset_ctrl_if.sv
// Board-side reset sources and core-side reset/cause outputs of the P1V reset controller.
interface p1v_reset_ctrl_if #(
    parameter int NUM_SRC = 2
);
    logic [NUM_SRC-1:0] src_in;
    logic               cause_clr;
    logic               res_out;
    logic               resn_out;
    logic [NUM_SRC:0]   res_cause;

    modport master (output src_in, cause_clr, input res_out, resn_out, res_cause);
    modport slave  (input src_in, cause_clr, output res_out, resn_out, res_cause);
endinterface

// File: rtl/p1v_reset_filter.sv
// One reset source: polarity normalise, synchronise, then optionally debounce to a qualified level.
module p1v_reset_filter
    import p1v_reset_pkg::*;
#(
    parameter int SYNC_STAGES     = P1V_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = P1V_DEBOUNCE_CYCLES,
    parameter bit DEBOUNCE        = 1'b1,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic src_i,
    output logic qual_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;

    // NOTE: the synchroniser resets to the inactive level, so a source already active at power-up
    // still travels the full sync/debounce path before it is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], src_i ^ ACTIVE_LOW};
    end

    assign synced = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE) begin : g_debounce
        localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
        localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

        logic [CW-1:0] cnt_q, cnt_d;
        logic          qual_q, qual_d;

        // NOTE: every always_comb output gets a default first; a missed branch would infer a latch.
        always_comb begin
            cnt_d  = '0;
            qual_d = qual_q;
            if (synced != qual_q) begin
                if (cnt_q == DEB_LAST) qual_d = synced;
                else                   cnt_d  = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q  <= '0;
                qual_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                qual_q <= qual_d;
            end
        end

        assign qual_o = qual_q;
    end else begin : g_bypass
        assign qual_o = synced;
    end

endmodule

// File: rtl/p1v_reset_ctrl.sv
// P1V reset controller: merges filtered sources, sequences POR/HOLD/STRETCH/RUN, keeps a sticky cause.
module p1v_reset_ctrl
    import p1v_reset_pkg::*;
#(
    parameter int         NUM_SRC         = P1V_NUM_SRC,
    parameter int         SYNC_STAGES     = P1V_SYNC_STAGES,
    parameter int         DEBOUNCE_CYCLES = P1V_DEBOUNCE_CYCLES,
    parameter logic [7:0] DEBOUNCE_MASK   = P1V_DEBOUNCE_MASK,
    parameter logic [7:0] ACTIVE_LOW_MASK = P1V_ACTIVE_LOW_MASK,
    parameter int         STRETCH_CYCLES  = P1V_STRETCH_CYCLES,
    parameter int         POR_CYCLES      = P1V_POR_CYCLES
) (
    input  logic             clock_160,
    input  logic             async_res,
    p1v_reset_ctrl_if.slave  bus
);
    localparam int            CW           = cnt_w(max3(POR_CYCLES, STRETCH_CYCLES, DEBOUNCE_CYCLES));
    localparam logic [CW-1:0] POR_LAST     = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);

    if (NUM_SRC < 1 || NUM_SRC > 8) begin : g_bad_num_src
        $error("p1v_reset_ctrl: NUM_SRC must be 1..8");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("p1v_reset_ctrl: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("p1v_reset_ctrl: DEBOUNCE_CYCLES must be >= 2");
    end
    if (STRETCH_CYCLES < 1 || POR_CYCLES < 1) begin : g_bad_hold
        $error("p1v_reset_ctrl: STRETCH_CYCLES and POR_CYCLES must be >= 1");
    end

    logic [NUM_SRC-1:0] qual;
    logic               any_act;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        p1v_reset_filter #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DEBOUNCE        (DEBOUNCE_MASK[i]),
            .ACTIVE_LOW      (ACTIVE_LOW_MASK[i])
        ) u_filter (
            .clk    (clock_160),
            .rst    (async_res),
            .src_i  (bus.src_in[i]),
            .qual_o (qual[i])
        );
    end

    assign any_act = |qual;

    reset_state_t     state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             res_q, resn_q;
    logic [NUM_SRC:0] cause_q, cause_d;

    // The shared counter only advances in POR and STRETCH and never passes its terminal value.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            POR: begin
                if (cnt_q == POR_LAST) state_d = any_act ? HOLD : RUN;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            HOLD: begin
                if (!any_act) state_d = STRETCH;
            end
            STRETCH: begin
                if (any_act)                    state_d = HOLD;
                else if (cnt_q == STRETCH_LAST) state_d = RUN;
                else                            cnt_d   = cnt_q + 1'b1;
            end
            RUN: begin
                if (any_act) state_d = HOLD;
            end
            default: state_d = POR;
        endcase
    end

    always_comb begin
        cause_d              = bus.cause_clr ? '0 : cause_q;
        cause_d[NUM_SRC-1:0] = cause_d[NUM_SRC-1:0] | qual;
    end

    // NOTE: res and resn are two flops fed from state_d, so both switch on the same edge without a gate after them.
    always_ff @(posedge clock_160 or posedge async_res) begin
        if (async_res) begin
            state_q <= POR;
            cnt_q   <= '0;
            res_q   <= 1'b1;
            resn_q  <= 1'b0;
            cause_q <= {1'b1, {NUM_SRC{1'b0}}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= (state_d != RUN);
            resn_q  <= (state_d == RUN);
            cause_q <= cause_d;
        end
    end

    assign bus.res_out   = res_q;
    assign bus.resn_out  = resn_q;
    assign bus.res_cause = cause_q;

endmodule

// File: tb/tb_p1v_reset_ctrl.sv
// Bench for p1v_reset_ctrl: directed latency checks plus random source activity against a window-based model.
`timescale 1ns/1ps
module tb_p1v_reset_ctrl;

    localparam int         NUM_SRC  = 2;
    localparam int         SYNC     = 2;
    localparam int         DEB_CYC  = 8;
    localparam int         STRETCH  = 16;
    localparam int         POR_CYC  = 32;
    localparam logic [1:0] DEB_MASK = 2'b01;
    localparam logic [1:0] AL_MASK  = 2'b10;
    localparam int         MAXE     = 8192;

    logic clk       = 1'b0;
    logic async_res = 1'b0;
    always #5 clk = ~clk;

    p1v_reset_ctrl_if #(.NUM_SRC(NUM_SRC)) bus ();

    p1v_reset_ctrl #(
        .NUM_SRC         (NUM_SRC),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB_CYC),
        .DEBOUNCE_MASK   (8'h01),
        .ACTIVE_LOW_MASK (8'h02),
        .STRETCH_CYCLES  (STRETCH),
        .POR_CYCLES      (POR_CYC)
    ) dut (
        .clock_160 (clk),
        .async_res (async_res),
        .bus       (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. e counts edges since async_res released; a source's qualified level
    // flips once its synchronised value has disagreed with it for DEB_CYC consecutive edges.
    // Reset is held while any qualified activity lies within the last STRETCH+1 edges.
    int         e        = 0;
    int         last_act = -1000;
    logic       res_exp   = 1'b1;
    logic [2:0] cause_exp = 3'b100;
    bit         pin_h [NUM_SRC][MAXE];
    bit         q_h   [NUM_SRC][MAXE];

    function automatic bit synced_at(input int s, input int n);
        int k;
        k = n - SYNC + 1;
        if (k < 1) return 1'b0;
        return pin_h[s][k];
    endfunction

    always @(posedge clk) begin
        bit act;
        bit prev;
        bit all_diff;
        if (async_res) begin
            e         = 0;
            last_act  = -1000;
            res_exp   = 1'b1;
            cause_exp = 3'b100;
            for (int s = 0; s < NUM_SRC; s++) q_h[s][0] = 1'b0;
        end else if (e < MAXE - 1) begin
            e++;
            res_exp   = (e < POR_CYC) || (last_act >= e - STRETCH - 1);
            cause_exp = (bus.cause_clr ? 3'b000 : cause_exp) | {1'b0, q_h[1][e-1], q_h[0][e-1]};
            act = 1'b0;
            for (int s = 0; s < NUM_SRC; s++) begin
                pin_h[s][e] = bus.src_in[s] ^ AL_MASK[s];
                if (DEB_MASK[s]) begin
                    prev     = q_h[s][e-1];
                    all_diff = 1'b1;
                    for (int j = 1; j <= DEB_CYC; j++)
                        if (synced_at(s, e - j) == prev) all_diff = 1'b0;
                    q_h[s][e] = all_diff ? !prev : prev;
                end else begin
                    q_h[s][e] = synced_at(s, e);
                end
                act |= q_h[s][e];
            end
            if (act && e >= POR_CYC - 1) last_act = e;
        end else begin
            n_err++;
            $display("FAIL model_depth: got %0d expected below %0d", e, MAXE - 1);
            $fatal(1, "model history exhausted");
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("res_out",   32'(bus.res_out),   32'(res_exp));
            check("resn_out",  32'(bus.resn_out),  32'(!res_exp));
            check("res_cause", 32'(bus.res_cause), 32'(cause_exp));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts negedges until res_out reaches lvl; returns limit+1 when the bound expires.
    task automatic wait_res(input logic lvl, input int limit, output int k);
        k = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (bus.res_out === lvl) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int k;
        int t;
        bus.src_in    = 2'b10;
        bus.cause_clr = 1'b0;
        #1 async_res = 1'b1;
        tick(1);
        chk_en = 1'b1;
        tick(2);

        // Power-on hold
        async_res = 1'b0;
        wait_res(1'b0, 100, k);
        check("por_len", 32'(k), 32'd32);
        check("por_resn", 32'(bus.resn_out), 32'd1);
        check("por_cause", 32'(bus.res_cause), 32'b100);

        // Short pulses on the debounced source are filtered, a long one resets
        for (int p = 0; p < 3; p++) begin
            bus.src_in[0] = 1'b1;
            tick(5);
            bus.src_in[0] = 1'b0;
            tick(5);
        end
        tick(5);
        check("glitch_res", 32'(bus.res_out), 32'd0);
        bus.src_in[0] = 1'b1;
        wait_res(1'b1, 60, k);
        check("deb_rise", 32'(k), 32'd11);
        tick(40 - k);
        bus.src_in[0] = 1'b0;
        wait_res(1'b0, 60, k);
        check("deb_fall", 32'(k), 32'd27);
        check("deb_cause0", 32'(bus.res_cause[0]), 32'd1);

        // One-cycle pulse on the bypassed active-low source
        tick(5);
        bus.src_in[1] = 1'b0;
        tick(1);
        bus.src_in[1] = 1'b1;
        t = 1;
        wait_res(1'b1, 20, k);
        t += k;
        check("bp_rise", 32'(t), 32'd3);
        wait_res(1'b0, 40, k);
        t += k;
        check("bp_fall", 32'(t), 32'd20);
        check("bp_cause1", 32'(bus.res_cause[1]), 32'd1);

        // Re-pulse seen while the stretch count is 10 restarts the stretch
        tick(5);
        bus.src_in[1] = 1'b0;
        tick(1);
        bus.src_in[1] = 1'b1;
        tick(11);
        bus.src_in[1] = 1'b0;
        tick(1);
        bus.src_in[1] = 1'b1;
        wait_res(1'b0, 40, k);
        check("restretch_fall", 32'(k + 1), 32'd20);

        // Clear on the first edge the debounced source is qualified: set wins
        tick(5);
        bus.src_in[0] = 1'b1;
        tick(10);
        bus.cause_clr = 1'b1;
        tick(1);
        bus.cause_clr = 1'b0;
        check("clr_vs_set", 32'(bus.res_cause), 32'b001);
        bus.src_in[0] = 1'b0;
        tick(40);

        // async_res during STRETCH acts without a clock edge
        bus.src_in[1] = 1'b0;
        tick(1);
        bus.src_in[1] = 1'b1;
        tick(8);
        #2 async_res = 1'b1;
        #1;
        check("async_stretch_res", 32'(bus.res_out), 32'd1);
        check("async_stretch_resn", 32'(bus.resn_out), 32'd0);
        check("async_stretch_cause", 32'(bus.res_cause), 32'b100);
        @(negedge clk);
        async_res = 1'b0;
        wait_res(1'b0, 100, k);
        check("por_len2", 32'(k), 32'd32);

        // async_res while running
        tick(3);
        #2 async_res = 1'b1;
        #1;
        check("async_run_res", 32'(bus.res_out), 32'd1);
        check("async_run_resn", 32'(bus.resn_out), 32'd0);
        @(negedge clk);
        async_res = 1'b0;
        wait_res(1'b0, 100, k);
        check("por_len3", 32'(k), 32'd32);

        // Random source activity, clears and occasional async resets
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(5, 0) == 0) bus.src_in[0] = !bus.src_in[0];
            if ($urandom_range(9, 0) == 0) bus.src_in[1] = !bus.src_in[1];
            bus.cause_clr = ($urandom_range(15, 0) == 0);
            if ($urandom_range(199, 0) == 0) begin
                #2 async_res = 1'b1;
                tick(1);
                async_res = 1'b0;
            end else begin
                tick(1);
            end
        end
        bus.src_in    = 2'b10;
        bus.cause_clr = 1'b0;
        tick(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
